// File: rtl/uart_pkg.sv
// Shared definitions for the UART register file: register indices, field
// positions inside CTRL/STATUS/ISR, and the reset baud divisor.
package uart_pkg;

  typedef enum logic [3:0] {
    REG_TXDATA = 4'd0,
    REG_RXDATA = 4'd1,
    REG_STATUS = 4'd2,
    REG_CTRL   = 4'd3,
    REG_BAUD   = 4'd4,
    REG_IER    = 4'd5,
    REG_ISR    = 4'd6
  } reg_idx_e;

  localparam int ISR_W        = 4;
  localparam int ISR_RX_AVAIL = 0;
  localparam int ISR_TX_EMPTY = 1;
  localparam int ISR_RX_OVF   = 2;
  localparam int ISR_TX_OVF   = 3;

  // CTRL[4:0] = {tx_en, rx_en, parity_en, parity_odd, stop2}
  localparam int CTRL_W          = 5;
  localparam int CTRL_STOP2      = 0;
  localparam int CTRL_PARITY_ODD = 1;
  localparam int CTRL_PARITY_EN  = 2;
  localparam int CTRL_RX_EN      = 3;
  localparam int CTRL_TX_EN      = 4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_LEVEL = 8;
  localparam int ST_RX_LEVEL = 16;

  localparam int RX_VALID_BIT = 8;

  localparam logic [15:0] BAUD_RESET = 16'd868;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt enable/status registers and the registered interrupt line.
// Sticky overflow bits favour a new set event over a coincident W1C.
module uart_irq_ctrl
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ier_we,
  input  logic [ISR_W-1:0] ier_wdata,
  input  logic             w1c_rx_ovf,
  input  logic             w1c_tx_ovf,
  input  logic             rx_overrun,
  input  logic             tx_ovf_set,
  input  logic             rx_empty,
  input  logic             tx_empty,
  output logic [ISR_W-1:0] ier,
  output logic [ISR_W-1:0] isr,
  output logic             irq
);

  logic [ISR_W-1:0] ier_q, ier_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             irq_q, irq_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    isr               = '0;
    isr[ISR_RX_AVAIL] = ~rx_empty;
    isr[ISR_TX_EMPTY] = tx_empty;
    isr[ISR_RX_OVF]   = rx_ovf_q;
    isr[ISR_TX_OVF]   = tx_ovf_q;

    ier_d    = ier_we ? ier_wdata : ier_q;
    rx_ovf_d = rx_overrun | (rx_ovf_q & ~w1c_rx_ovf);
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~w1c_tx_ovf);
    irq_d    = |(isr & ier_q);
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_q    <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ier_q    <= ier_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign ier = ier_q;
  assign irq = irq_q;

endmodule

// File: rtl/uart_regfile.sv
// UART register file: bus decode, CTRL/BAUD storage, TX push / RX pop
// generation and the interrupt sub-block. Writes commit the cycle after reg_wen.
module uart_regfile
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int FIFO_AW        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0]     reg_wdata,
  input  logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  input  logic                      reg_wen,
  input  logic                      reg_ren,
  output logic [DATA_WIDTH-1:0]     reg_rdata,
  output logic                      reg_error,
  output logic                      tx_push,
  output logic [7:0]                tx_wdata,
  input  logic                      tx_full,
  input  logic                      tx_empty,
  input  logic [FIFO_AW:0]          tx_level,
  output logic                      rx_pop,
  input  logic [7:0]                rx_rdata,
  input  logic                      rx_full,
  input  logic                      rx_empty,
  input  logic [FIFO_AW:0]          rx_level,
  input  logic                      rx_overrun,
  output logic [15:0]               baud_div,
  output logic                      tx_en,
  output logic                      rx_en,
  output logic                      parity_en,
  output logic                      parity_odd,
  output logic                      stop2,
  output logic                      irq
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [REG_ADDR_WIDTH-1:0] A_TXDATA = REG_ADDR_WIDTH'(REG_TXDATA);
  localparam logic [REG_ADDR_WIDTH-1:0] A_RXDATA = REG_ADDR_WIDTH'(REG_RXDATA);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS = REG_ADDR_WIDTH'(REG_STATUS);
  localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL   = REG_ADDR_WIDTH'(REG_CTRL);
  localparam logic [REG_ADDR_WIDTH-1:0] A_BAUD   = REG_ADDR_WIDTH'(REG_BAUD);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IER    = REG_ADDR_WIDTH'(REG_IER);
  localparam logic [REG_ADDR_WIDTH-1:0] A_ISR    = REG_ADDR_WIDTH'(REG_ISR);

  logic              wen_q, wen_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       baud_q, baud_d;
  logic              ren_q, ren_d;
  logic              seen_q, seen_d;

  logic sel_tx, sel_rx, sel_status, sel_ctrl, sel_baud, sel_ier, sel_isr, mapped;
  logic rd_now, tx_wr, tx_ovf_set;
  logic [ISR_W-1:0]      ier, isr;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    sel_tx     = 1'b0;
    sel_rx     = 1'b0;
    sel_status = 1'b0;
    sel_ctrl   = 1'b0;
    sel_baud   = 1'b0;
    sel_ier    = 1'b0;
    sel_isr    = 1'b0;
    case (reg_addr)
      A_TXDATA: sel_tx     = 1'b1;
      A_RXDATA: sel_rx     = 1'b1;
      A_STATUS: sel_status = 1'b1;
      A_CTRL:   sel_ctrl   = 1'b1;
      A_BAUD:   sel_baud   = 1'b1;
      A_IER:    sel_ier    = 1'b1;
      A_ISR:    sel_isr    = 1'b1;
      default:  ;
    endcase
    mapped = sel_tx | sel_rx | sel_status | sel_ctrl | sel_baud | sel_ier | sel_isr;
  end

  assign reg_error = ~mapped | (reg_wen & (sel_rx | sel_status));

  always_comb begin
    rdata = '0;
    if (sel_rx) begin
      rdata[7:0]          = rx_rdata;
      rdata[RX_VALID_BIT] = ~rx_empty;
    end
    if (sel_status) begin
      rdata[ST_TX_FULL]                 = tx_full;
      rdata[ST_TX_EMPTY]                = tx_empty;
      rdata[ST_RX_FULL]                 = rx_full;
      rdata[ST_RX_EMPTY]                = rx_empty;
      rdata[ST_TX_LEVEL +: FIFO_AW + 1] = tx_level;
      rdata[ST_RX_LEVEL +: FIFO_AW + 1] = rx_level;
    end
    if (sel_ctrl) rdata[CTRL_W-1:0] = ctrl_q;
    if (sel_baud) rdata[15:0]       = baud_q;
    if (sel_ier)  rdata[ISR_W-1:0]  = ier;
    if (sel_isr)  rdata[ISR_W-1:0]  = isr;
  end

  assign reg_rdata = rdata;

  // The commit cycle uses whatever address/data/strobe are present while wen_q is high.
  always_comb begin
    wen_d  = reg_wen;
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    if (wen_q && sel_ctrl && reg_wstrb[0]) ctrl_d = reg_wdata[CTRL_W-1:0];
    if (wen_q && sel_baud) begin
      if (reg_wstrb[0]) baud_d[7:0]  = reg_wdata[7:0];
      if (reg_wstrb[1]) baud_d[15:8] = reg_wdata[15:8];
    end

    rd_now = reg_ren & sel_rx;
    ren_d  = rd_now;
    seen_d = rd_now & ren_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      ctrl_q <= '0;
      baud_q <= BAUD_RESET;
      ren_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      ctrl_q <= ctrl_d;
      baud_q <= baud_d;
      ren_q  <= ren_d;
      seen_q <= seen_d;
    end
  end

  // Push/pop are decoded from reset-cleared state, so both are low during reset.
  assign tx_wr      = wen_q & sel_tx & reg_wstrb[0];
  assign tx_push    = tx_wr & ~tx_full;
  assign tx_ovf_set = tx_wr & tx_full;
  assign tx_wdata   = reg_wdata[7:0];
  assign rx_pop     = rd_now & ren_q & ~seen_q & ~rx_empty;

  uart_irq_ctrl u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .ier_we     (wen_q & sel_ier & reg_wstrb[0]),
    .ier_wdata  (reg_wdata[ISR_W-1:0]),
    .w1c_rx_ovf (wen_q & sel_isr & reg_wstrb[0] & reg_wdata[ISR_RX_OVF]),
    .w1c_tx_ovf (wen_q & sel_isr & reg_wstrb[0] & reg_wdata[ISR_TX_OVF]),
    .rx_overrun (rx_overrun),
    .tx_ovf_set (tx_ovf_set),
    .rx_empty   (rx_empty),
    .tx_empty   (tx_empty),
    .ier        (ier),
    .isr        (isr),
    .irq        (irq)
  );

  assign baud_div   = baud_q;
  assign tx_en      = ctrl_q[CTRL_TX_EN];
  assign rx_en      = ctrl_q[CTRL_RX_EN];
  assign parity_en  = ctrl_q[CTRL_PARITY_EN];
  assign parity_odd = ctrl_q[CTRL_PARITY_ODD];
  assign stop2      = ctrl_q[CTRL_STOP2];

  logic unused_bits;
  assign unused_bits = ^{reg_wdata[DATA_WIDTH-1:16], reg_wstrb[STRB_W-1:2]};

endmodule

// File: tb/tb_uart_regfile.sv
// Directed bench for uart_regfile: a table of combinational read/error
// vectors followed by hand-written multi-cycle sequences.
module tb_uart_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_wen, reg_ren;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        tx_push;
  logic [7:0]  tx_wdata;
  logic        tx_full, tx_empty;
  logic [4:0]  tx_level;
  logic        rx_pop;
  logic [7:0]  rx_rdata;
  logic        rx_full, rx_empty;
  logic [4:0]  rx_level;
  logic        rx_overrun;
  logic [15:0] baud_div;
  logic        tx_en, rx_en, parity_en, parity_odd, stop2;
  logic        irq;

  always #5 clk = ~clk;

  uart_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb),
    .reg_wen    (reg_wen),
    .reg_ren    (reg_ren),
    .reg_rdata  (reg_rdata),
    .reg_error  (reg_error),
    .tx_push    (tx_push),
    .tx_wdata   (tx_wdata),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .tx_level   (tx_level),
    .rx_pop     (rx_pop),
    .rx_rdata   (rx_rdata),
    .rx_full    (rx_full),
    .rx_empty   (rx_empty),
    .rx_level   (rx_level),
    .rx_overrun (rx_overrun),
    .baud_div   (baud_div),
    .tx_en      (tx_en),
    .rx_en      (rx_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;

  always @(negedge clk) begin
    if (tx_push) push_cnt++;
    if (rx_pop)  pop_cnt++;
  end

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic        wen;
    logic        tf, te, rf, re;
    logic [4:0]  tl, rl;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    step();
    reg_addr = a; reg_wdata = d; reg_wstrb = s; reg_wen = 1'b1;
    step();
    reg_wen = 1'b0;
    step();
    #3;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    step();
    reg_addr = a;
    #3;
    check(name, reg_rdata, exp);
  endtask

  task automatic rx_hold(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      reg_addr = 4'd1;
      reg_ren  = 1'b1;
    end
    step();
    reg_ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;

    //          name            addr  wen tf te rf re  tl      rl      rdata          err
    vecs[0]  = '{"baud_rst",    4'd4, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0000_0364, 1'b0};
    vecs[1]  = '{"ctrl_rst",    4'd3, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b0};
    vecs[2]  = '{"ier_rst",     4'd5, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b0};
    vecs[3]  = '{"isr_rst",     4'd6, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h2,         1'b0};
    vecs[4]  = '{"status_idle", 4'd2, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'hA,         1'b0};
    vecs[5]  = '{"rxdata_empty",4'd1, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h05A,       1'b0};
    vecs[6]  = '{"txdata_read", 4'd0, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b0};
    vecs[7]  = '{"unmapped_7",  4'd7, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b1};
    vecs[8]  = '{"unmapped_9",  4'd9, 0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b1};
    vecs[9]  = '{"unmapped_15", 4'd15,0, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0,         1'b1};
    vecs[10] = '{"status_busy", 4'd2, 0, 1, 0, 0, 0, 5'h10, 5'd3,  32'h0003_1001, 1'b0};
    vecs[11] = '{"isr_levels",  4'd6, 0, 1, 0, 0, 0, 5'h10, 5'd3,  32'h1,         1'b0};
    vecs[12] = '{"rxdata_valid",4'd1, 0, 1, 0, 0, 0, 5'h10, 5'd3,  32'h15A,       1'b0};
    vecs[13] = '{"wr_status",   4'd2, 1, 0, 1, 0, 1, 5'd0,  5'd0,  32'hA,         1'b1};
    vecs[14] = '{"wr_rxdata",   4'd1, 1, 0, 1, 0, 1, 5'd0,  5'd0,  32'h05A,       1'b1};
    vecs[15] = '{"wr_baud_ok",  4'd4, 1, 0, 1, 0, 1, 5'd0,  5'd0,  32'h0000_0364, 1'b0};
    vecs[16] = '{"status_rxfull",4'd2,0, 0, 1, 1, 0, 5'd0,  5'h10, 32'h0010_0006, 1'b0};

    rst_n = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_wstrb = '0; reg_wen = 1'b0; reg_ren = 1'b0;
    tx_full = 1'b0; tx_empty = 1'b1; tx_level = '0;
    rx_full = 1'b0; rx_empty = 1'b1; rx_level = '0; rx_rdata = 8'h5A;
    rx_overrun = 1'b0;
    #23 rst_n = 1'b1;

    #1;
    check("irq_rst", 32'(irq), 32'd0);
    check("baud_div_rst", 32'(baud_div), 32'h364);
    check("ctrl_out_rst", 32'({tx_en, rx_en, parity_en, parity_odd, stop2}), 32'h0);

    // Combinational read / error table; zero strobes keep the wen rows harmless.
    for (int i = 0; i < NV; i++) begin
      step();
      reg_addr = vecs[i].addr; reg_wen = vecs[i].wen; reg_wstrb = 4'h0; reg_wdata = '0;
      tx_full = vecs[i].tf; tx_empty = vecs[i].te; rx_full = vecs[i].rf; rx_empty = vecs[i].re;
      tx_level = vecs[i].tl; rx_level = vecs[i].rl;
      #3;
      check({vecs[i].name, "_rdata"}, reg_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(reg_error), 32'(vecs[i].exp_err));
    end
    step();
    reg_wen = 1'b0;
    tx_full = 1'b0; tx_empty = 1'b1; rx_full = 1'b0; rx_empty = 1'b1; tx_level = '0; rx_level = '0;
    read_check("baud_after_table", 4'd4, 32'h364);

    // TXDATA write with room in the FIFO.
    base = push_cnt;
    step();
    reg_addr = 4'd0; reg_wdata = 32'h41; reg_wstrb = 4'hF; reg_wen = 1'b1;
    #3 check("tx_push_wen_cycle", 32'(tx_push), 32'd0);
    step();
    reg_wen = 1'b0;
    #3 check("tx_push_commit", 32'(tx_push), 32'd1);
    check("tx_wdata", 32'(tx_wdata), 32'h41);
    step();
    #3 check("tx_push_after", 32'(tx_push), 32'd0);
    check("tx_push_count", 32'(push_cnt - base), 32'd1);

    // TXDATA write into a full FIFO.
    tx_full = 1'b1;
    base = push_cnt;
    step();
    reg_wen = 1'b1;
    step();
    reg_wen = 1'b0;
    #3 check("tx_full_no_push", 32'(tx_push), 32'd0);
    step();
    tx_empty = 1'b0;
    check("tx_full_push_count", 32'(push_cnt - base), 32'd0);
    read_check("isr_tx_ovf", 4'd6, 32'h8);
    tx_full = 1'b0;
    write_reg(4'd6, 32'h8, 4'h1);
    check("isr_tx_ovf_w1c", reg_rdata, 32'h0);

    // RX read held three cycles with data available.
    rx_empty = 1'b0;
    base = pop_cnt;
    step();
    reg_addr = 4'd1; reg_ren = 1'b1;
    #3 check("rxdata_valid_rd", reg_rdata, 32'h15A);
    check("rx_pop_cycle1", 32'(rx_pop), 32'd0);
    step();
    #3 check("rx_pop_cycle2", 32'(rx_pop), 32'd1);
    step();
    #3 check("rx_pop_cycle3", 32'(rx_pop), 32'd0);
    step();
    reg_ren = 1'b0;
    step();
    check("rx_pop_count_3", 32'(pop_cnt - base), 32'd1);

    base = pop_cnt;
    rx_hold(4);
    rx_hold(2);
    rx_hold(1);
    check("rx_pop_rearm", 32'(pop_cnt - base), 32'd2);

    rx_empty = 1'b1;
    base = pop_cnt;
    step();
    reg_addr = 4'd1; reg_ren = 1'b1;
    #3 check("rxdata_empty_rd", reg_rdata, 32'h05A);
    step();
    step();
    step();
    reg_ren = 1'b0;
    step();
    check("rx_pop_empty", 32'(pop_cnt - base), 32'd0);

    // Byte-strobed BAUD and CTRL writes.
    write_reg(4'd4, 32'hAAAA_1234, 4'b0001);
    check("baud_div_lowbyte", 32'(baud_div), 32'h0334);
    read_check("baud_read", 4'd4, 32'h0334);
    write_reg(4'd3, 32'h15, 4'b0001);
    check("ctrl_out", 32'({tx_en, rx_en, parity_en, parity_odd, stop2}), 32'h15);
    write_reg(4'd3, 32'h0A, 4'b0000);
    check("ctrl_nostrb", reg_rdata, 32'h15);

    // Interrupt path on rx_overrun.
    tx_empty = 1'b0; rx_empty = 1'b1;
    write_reg(4'd5, 32'h4, 4'h1);
    check("ier_read", reg_rdata, 32'h4);
    step();
    reg_addr = 4'd6; rx_overrun = 1'b1;
    step();
    rx_overrun = 1'b0;
    #3 check("isr_rx_ovf", reg_rdata, 32'h4);
    check("irq_latency", 32'(irq), 32'd0);
    step();
    #3 check("irq_set", 32'(irq), 32'd1);

    step();
    reg_wdata = 32'h4; reg_wstrb = 4'h1; reg_wen = 1'b1;
    step();
    reg_wen = 1'b0;
    step();
    #3 check("isr_w1c_clear", reg_rdata, 32'h0);
    step();
    #3 check("irq_cleared", 32'(irq), 32'd0);

    step();
    rx_overrun = 1'b1;
    step();
    rx_overrun = 1'b0;
    step();
    #3 check("irq_set_again", 32'(irq), 32'd1);
    step();
    reg_wdata = 32'h4; reg_wstrb = 4'h1; reg_wen = 1'b1;
    step();
    reg_wen = 1'b0; rx_overrun = 1'b1;
    step();
    rx_overrun = 1'b0;
    #3 check("isr_set_wins", reg_rdata, 32'h4);
    step();
    #3 check("irq_set_wins", 32'(irq), 32'd1);

    // Write to STATUS is rejected and changes nothing.
    step();
    reg_addr = 4'd2; reg_wdata = 32'hFFFF_FFFF; reg_wstrb = 4'hF; reg_wen = 1'b1;
    #3 check("wr_status_err", 32'(reg_error), 32'd1);
    step();
    reg_wen = 1'b0;
    step();
    read_check("ctrl_kept", 4'd3, 32'h15);
    read_check("baud_kept", 4'd4, 32'h0334);
    read_check("ier_kept", 4'd5, 32'h4);
    read_check("isr_kept", 4'd6, 32'h4);

    // Reset between reg_wen and commit discards the write.
    step();
    reg_addr = 4'd4; reg_wdata = 32'h5555; reg_wstrb = 4'h3; reg_wen = 1'b1;
    step();
    reg_wen = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    #3 check("baud_pending_discard", 32'(baud_div), 32'h364);
    check("ctrl_out_reset", 32'({tx_en, rx_en, parity_en, parity_odd, stop2}), 32'h0);
    check("irq_reset", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
